zbb_seq: RTL

ZBB_SEQ -- requirements
Module: zbb_seq

---
 rtl/zbb_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/zbb_seq.sv
// Sequential CLZ / CTZ / CPOP unit: one 4-bit nibble per RUN cycle, 8 cycles per op.
// Optional macro ZBB_SEQ_EARLY_EXIT_EN: CLZ/CTZ finish on the first nonzero nibble.
module zbb_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rd,
  output logic        busy
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned ACC_W    = 6;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned ADD_W    = 3;
  localparam int unsigned CNT_LAST = 7;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_CPOP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_op;
  logic [XLEN-1:0]    r_rs1;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_found;

  logic [CNT_W-1:0]   w_idx;
  logic [NIB_W-1:0]   w_nib;
  logic [ADD_W-1:0]   w_add;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_nz;
  logic               w_last;

  function automatic logic [ADD_W-1:0] f_lz4(input logic [NIB_W-1:0] n);
    casez (n)
      4'b1???: return 3'd0;
      4'b01??: return 3'd1;
      4'b001?: return 3'd2;
      4'b0001: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [ADD_W-1:0] f_tz4(input logic [NIB_W-1:0] n);
    casez (n)
      4'b???1: return 3'd0;
      4'b??10: return 3'd1;
      4'b?100: return 3'd2;
      4'b1000: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [ADD_W-1:0] f_pop4(input logic [NIB_W-1:0] n);
    return ADD_W'(n[0]) + ADD_W'(n[1]) + ADD_W'(n[2]) + ADD_W'(n[3]);
  endfunction

  // Nibble select (CLZ walks from the top) and per-nibble contribution
  always_comb begin
    w_idx = (r_op == OP_CLZ) ? (CNT_W'(CNT_LAST) - r_cnt) : r_cnt;
    w_nib = r_rs1[{w_idx, 2'b00} +: NIB_W];
    w_nz  = |w_nib;
    w_add = '0;
    case (r_op)
      OP_CLZ:  if (!r_found) w_add = f_lz4(w_nib);
      OP_CTZ:  if (!r_found) w_add = f_tz4(w_nib);
      OP_CPOP: w_add = f_pop4(w_nib);
      default: w_add = '0;
    endcase
    w_acc_next = r_acc + ACC_W'(w_add);
    w_last     = (r_cnt == CNT_W'(CNT_LAST));
`ifdef ZBB_SEQ_EARLY_EXIT_EN
    if (((r_op == OP_CLZ) || (r_op == OP_CTZ)) && w_nz) w_last = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_rs1      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_found    <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rd    <= '0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            r_op      <= req_op;
            r_rs1     <= req_rs1;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_found   <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_op == OP_RSVD) begin
              r_state    <= DONE;
              resp_valid <= 1'b1;
              resp_rd    <= '0;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_found <= r_found | w_nz;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state    <= DONE;
            resp_valid <= 1'b1;
            resp_rd    <= XLEN'(w_acc_next);
          end
        end
        DONE: begin
          // Handoff returns to IDLE; req_ready only rises afterwards
          if (resp_ready) begin
            r_state    <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
